// File: rtl/dps_dev_arb_pkg.sv
// dps_dev_arb_pkg: shared state type and constants for the device-query arbiter
package dps_dev_arb_pkg;
  localparam int DATA_W      = 32;
  localparam int DEF_N_REQ   = 4;
  localparam int DEF_TIMEOUT = 16;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} arbState;
endpackage

// File: rtl/dps_rr_picker.sv
// dps_rr_picker: combinational round-robin pick, searching upward from lastGrant+1
//   reqVec      in   N_REQ  request levels
//   lastGrant   in   index  most recently served requester
//   grantOneHot out  N_REQ  one-hot pick, all-zero when nothing requests
//   grantIdx    out  index  binary index of the pick
module dps_rr_picker #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         reqVec,
  input  logic [$clog2(N_REQ)-1:0] lastGrant,
  output logic [N_REQ-1:0]         grantOneHot,
  output logic [$clog2(N_REQ)-1:0] grantIdx
);
  localparam int IW = $clog2(N_REQ);
  logic [IW-1:0] cand;
  // Walk candidates farthest-first so the nearest requester after lastGrant overwrites the rest.
  always_comb begin
    cand     = '0;
    grantIdx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IW'((int'(lastGrant) + k) % N_REQ);
      if (reqVec[cand]) grantIdx = cand;
    end
    grantOneHot = (|reqVec) ? N_REQ'(1) << grantIdx : '0;
  end
endmodule

// File: rtl/dps_dev_arbiter.sv
// dps_dev_arbiter: round-robin arbiter sharing one device query port among N_REQ requesters
//   iCLOCK, iRESET                        clock; asynchronous active-high reset
//   iREQ_VALID / oREQ_ACCEPT              per-requester request levels / one-cycle accept pulse
//   oDEV_REQ_VALID                        one-cycle request pulse to the device
//   iDEV_RSP_VALID / iDEV_RSP_DATA        device response strobe and data
//   oRSP_VALID / oRSP_DATA / oRSP_ERROR   per-requester response pulse, data, timeout flag
//   DPS_DEV_ARBITER_TIMEOUT_EN: when defined, a WAIT lasting TIMEOUT cycles ends with oRSP_ERROR=1
module dps_dev_arbiter
  import dps_dev_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              iCLOCK,
  input  logic              iRESET,
  input  logic [N_REQ-1:0]  iREQ_VALID,
  output logic [N_REQ-1:0]  oREQ_ACCEPT,
  output logic              oDEV_REQ_VALID,
  input  logic              iDEV_RSP_VALID,
  input  logic [DATA_W-1:0] iDEV_RSP_DATA,
  output logic [N_REQ-1:0]  oRSP_VALID,
  output logic [DATA_W-1:0] oRSP_DATA,
  output logic              oRSP_ERROR
);
  localparam int IW = $clog2(N_REQ);
  arbState           state, stateNext;
  logic [IW-1:0]     grantIdx, grantIdxNext, lastGrant, lastGrantNext, pickIdx;
  logic [N_REQ-1:0]  pickOneHot, acceptNext, rspValidNext;
  logic              devReqNext;
  logic [DATA_W-1:0] rspDataNext;
`ifdef DPS_DEV_ARBITER_TIMEOUT_EN
  logic [7:0]        waitCnt, waitCntNext;
  logic              rspErrNext;
`else
  assign oRSP_ERROR = 1'b0;
`endif

  dps_rr_picker #(.N_REQ(N_REQ)) uPicker (
    .reqVec(iREQ_VALID),
    .lastGrant(lastGrant),
    .grantOneHot(pickOneHot),
    .grantIdx(pickIdx)
  );

  // All outputs are registered: the *Next values computed here appear one cycle later.
  always_comb begin
    stateNext     = state;
    grantIdxNext  = grantIdx;
    lastGrantNext = lastGrant;
    acceptNext    = '0;
    devReqNext    = 1'b0;
    rspValidNext  = '0;
    rspDataNext   = oRSP_DATA;
`ifdef DPS_DEV_ARBITER_TIMEOUT_EN
    waitCntNext   = '0;
    rspErrNext    = 1'b0;
`endif
    case (state)
      IDLE: if (|iREQ_VALID) begin
        stateNext    = WAIT;
        grantIdxNext = pickIdx;
        acceptNext   = pickOneHot;
        devReqNext   = 1'b1;
      end
      WAIT: if (iDEV_RSP_VALID) begin
        stateNext    = RESP;
        rspDataNext  = iDEV_RSP_DATA;
        rspValidNext = N_REQ'(1) << grantIdx;
      end
`ifdef DPS_DEV_ARBITER_TIMEOUT_EN
      else if (waitCnt == 8'(TIMEOUT - 1)) begin
        stateNext    = RESP;
        rspDataNext  = '0;
        rspErrNext   = 1'b1;
        rspValidNext = N_REQ'(1) << grantIdx;
      end else waitCntNext = waitCnt + 8'd1;
`endif
      RESP: begin
        stateNext     = IDLE;
        lastGrantNext = grantIdx;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK or posedge iRESET)
    if (iRESET) begin
      state          <= IDLE;
      grantIdx       <= '0;
      lastGrant      <= IW'(N_REQ - 1);
      oREQ_ACCEPT    <= '0;
      oDEV_REQ_VALID <= 1'b0;
      oRSP_VALID     <= '0;
      oRSP_DATA      <= '0;
    end else begin
      state          <= stateNext;
      grantIdx       <= grantIdxNext;
      lastGrant      <= lastGrantNext;
      oREQ_ACCEPT    <= acceptNext;
      oDEV_REQ_VALID <= devReqNext;
      oRSP_VALID     <= rspValidNext;
      oRSP_DATA      <= rspDataNext;
    end

`ifdef DPS_DEV_ARBITER_TIMEOUT_EN
  always_ff @(posedge iCLOCK or posedge iRESET)
    if (iRESET) begin
      waitCnt    <= '0;
      oRSP_ERROR <= 1'b0;
    end else begin
      waitCnt    <= waitCntNext;
      oRSP_ERROR <= rspErrNext;
    end
`endif
endmodule

// File: tb/tb_dps_dev_arbiter.sv
// tb_dps_dev_arbiter: randomized self-checking bench against a transaction-level arbiter model
module tb_dps_dev_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;
`ifdef DPS_DEV_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          iCLOCK, iRESET, oDEV_REQ_VALID, iDEV_RSP_VALID, oRSP_ERROR;
  logic [N-1:0]  iREQ_VALID, oREQ_ACCEPT, oRSP_VALID;
  logic [31:0]   iDEV_RSP_DATA, oRSP_DATA;

  int          vectors = 0, miscompares = 0;
  int          mLast;
  logic [31:0] mData;

  dps_dev_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .iCLOCK(iCLOCK), .iRESET(iRESET),
    .iREQ_VALID(iREQ_VALID), .oREQ_ACCEPT(oREQ_ACCEPT),
    .oDEV_REQ_VALID(oDEV_REQ_VALID),
    .iDEV_RSP_VALID(iDEV_RSP_VALID), .iDEV_RSP_DATA(iDEV_RSP_DATA),
    .oRSP_VALID(oRSP_VALID), .oRSP_DATA(oRSP_DATA), .oRSP_ERROR(oRSP_ERROR)
  );

  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  function automatic int rrPick(input int last, input logic [N-1:0] req);
    for (int i = 1; i <= N; i++)
      if (req[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  function automatic logic [41:0] outs();
    return {oREQ_ACCEPT, oDEV_REQ_VALID, oRSP_VALID, oRSP_DATA, oRSP_ERROR};
  endfunction

  task automatic test_reset();
    logic [41:0] act;
    iRESET = 1'b1; iREQ_VALID = '0; iDEV_RSP_VALID = 1'b0; iDEV_RSP_DATA = '0;
    repeat (2) @(negedge iCLOCK);
    act = outs();
    vectors++;
    if (act !== 42'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%h want=%h", act, 42'h0);
    end
    iRESET = 1'b0;
    mLast = N - 1;
    mData = '0;
  endtask

  // One full transaction, entered and left at an IDLE-cycle negedge; lat = WAIT cycle of device response.
  task automatic do_txn(input logic [N-1:0] req, input int lat, input logic [31:0] d, input string tag);
    int g, respK;
    logic err;
    logic [N-1:0] oh;
    logic [41:0] act, exp;
    g = rrPick(mLast, req);
    oh = N'(1) << g;
    err = TO_EN && lat >= TO;
    respK = err ? TO - 1 : lat;
    iREQ_VALID = req;
    iDEV_RSP_VALID = 1'b0;
    for (int k = 0; k <= respK; k++) begin
      @(negedge iCLOCK);
      act = outs();
      exp = {(k == 0) ? oh : {N{1'b0}}, k == 0, {N{1'b0}}, mData, 1'b0};
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL %s wait%0d got=%h want=%h", tag, k, act, exp);
      end
      iREQ_VALID = N'($urandom);
      iDEV_RSP_VALID = (k == lat);
      iDEV_RSP_DATA = (k == lat) ? d : $urandom;
    end
    @(negedge iCLOCK);
    act = outs();
    exp = {{N{1'b0}}, 1'b0, oh, err ? 32'h0 : d, err};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s resp got=%h want=%h", tag, act, exp);
    end
    mData = err ? 32'h0 : d;
    mLast = g;
    iREQ_VALID = '0;
    iDEV_RSP_VALID = 1'($urandom);
    iDEV_RSP_DATA = $urandom;
    @(negedge iCLOCK);
    act = outs();
    exp = {{N{1'b0}}, 1'b0, {N{1'b0}}, mData, 1'b0};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s idle got=%h want=%h", tag, act, exp);
    end
    iDEV_RSP_VALID = 1'b0;
  endtask

  // IDLE cycles with stray device strobes; the last cycle always strobes.
  task automatic idle_noise(input int n, input logic [31:0] junk, input string tag);
    logic [41:0] act, exp;
    for (int i = 0; i < n; i++) begin
      iREQ_VALID = '0;
      iDEV_RSP_VALID = (i == n - 1) || 1'($urandom);
      iDEV_RSP_DATA = junk;
      @(negedge iCLOCK);
      act = outs();
      exp = {{N{1'b0}}, 1'b0, {N{1'b0}}, mData, 1'b0};
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL %s idle%0d got=%h want=%h", tag, i, act, exp);
      end
    end
    iDEV_RSP_VALID = 1'b0;
  endtask

  task automatic test_basic();
    test_reset();
    do_txn(4'b0001, 1, 32'h0400_0000, "basic");
  endtask

  task automatic test_round_robin();
    test_reset();
    do_txn(4'b1111, 1, $urandom, "rr0");
    do_txn(4'b1110, 1, $urandom, "rr1");
    do_txn(4'b1100, 1, $urandom, "rr2");
    do_txn(4'b1000, 1, $urandom, "rr3");
  endtask

  task automatic test_wrap();
    do_txn(4'b0100, 0, $urandom, "wrap2");
    do_txn(4'b0101, 2, $urandom, "wrap0");
    do_txn(4'b0101, 1, $urandom, "wrap2b");
  endtask

  task automatic test_spurious();
    idle_noise(3, 32'hDEAD_BEEF, "spurious");
    do_txn(4'b0010, 1, 32'h1357_9BDF, "after_spurious");
  endtask

  task automatic test_timeout();
    do_txn(4'b0010, 20, 32'hCAFE_F00D, "timeout");
    idle_noise(5, 32'hCAFE_F00D, "late_rsp");
  endtask

  task automatic test_mid_reset();
    logic [41:0] act;
    iREQ_VALID = 4'b0100;
    @(negedge iCLOCK);
    iREQ_VALID = '0;
    #2 iRESET = 1'b1;
    #1 act = outs();
    vectors++;
    if (act !== 42'h0) begin
      miscompares++;
      $display("FAIL mid_reset got=%h want=%h", act, 42'h0);
    end
    @(negedge iCLOCK);
    iRESET = 1'b0;
    mLast = N - 1;
    mData = '0;
    idle_noise(3, 32'h1234_5678, "post_reset_rsp");
    do_txn(4'b1111, 1, $urandom, "post_reset_txn");
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    int lat;
    for (int t = 0; t < 60; t++) begin
      r = N'($urandom_range(1, (1 << N) - 1));
      lat = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 4);
      do_txn(r, lat, $urandom, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_wrap();
    test_spurious();
    test_timeout();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dps_dev_arbiter.md
DPS_DEV_ARBITER -- requirements
Module: dps_dev_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters sharing one device query port (legal 2..8).
REQ-002 Parameter TIMEOUT, default 16, SHALL set the maximum cycles spent waiting for a device response (legal 2..255).
REQ-003 Port iCLOCK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port iRESET  in  1  SHALL be the reset: asynchronous, active-high.
REQ-005 Port iREQ_VALID  in  N_REQ  SHALL carry per-requester request levels, held high until accepted.
REQ-006 Port oREQ_ACCEPT  out  N_REQ  SHALL carry a one-hot, one-cycle accept pulse to the granted requester.
REQ-007 Port oDEV_REQ_VALID  out  1  SHALL be a one-cycle request pulse to the shared device.
REQ-008 Port iDEV_RSP_VALID  in  1  SHALL be the device response strobe.
REQ-009 Port iDEV_RSP_DATA  in  32  SHALL be the device response data, valid with iDEV_RSP_VALID.
REQ-010 Port oRSP_VALID  out  N_REQ  SHALL carry a one-hot, one-cycle response pulse to the owning requester.
REQ-011 Port oRSP_DATA  out  32  SHALL carry response data, valid with oRSP_VALID.
REQ-012 Port oRSP_ERROR  out  1  SHALL flag a timed-out transaction, valid with oRSP_VALID.

Function
REQ-013 FSM SHALL have states IDLE, WAIT, RESP; exactly one transaction outstanding at any time.
REQ-014 IDLE: if any iREQ_VALID bit set, SHALL select grant g by round-robin starting at (last_grant+1) mod N_REQ, register g, go to WAIT; else stay IDLE.
REQ-015 On IDLE->WAIT, oREQ_ACCEPT[g] and oDEV_REQ_VALID SHALL be 1 for exactly the first WAIT cycle (registered outputs).
REQ-016 WAIT: iDEV_RSP_VALID=1 SHALL capture iDEV_RSP_DATA, clear error flag, go to RESP.
REQ-017 RESP: oRSP_VALID[g]=1, oRSP_DATA=captured data, oRSP_ERROR=captured flag for one cycle; last_grant<=g; next state IDLE.
REQ-018 Latency with a one-cycle device: request at cycle 0 -> accept/device request at cycle 1 -> device response at cycle 2 -> oRSP_VALID at cycle 3 -> IDLE at cycle 4.
REQ-019 iREQ_VALID SHALL be ignored in WAIT and RESP; a level still high in IDLE after accept is a new request.
REQ-020 iDEV_RSP_VALID in IDLE or RESP SHALL be ignored (no state or output change).
REQ-021 iDEV_RSP_VALID in the same cycle as oDEV_REQ_VALID SHALL be accepted as the response.
REQ-022 oRSP_DATA SHALL hold its last value when oRSP_VALID is all-zero.

Reset
REQ-023 While iRESET=1: state=IDLE, oREQ_ACCEPT=0, oDEV_REQ_VALID=0, oRSP_VALID=0, oRSP_DATA=32'h0, oRSP_ERROR=0, last_grant=N_REQ-1 (requester 0 wins first), timeout counter=0.
REQ-024 Reset mid-transaction SHALL abandon it without emitting any response; a later device response lands in IDLE and is ignored.

Configuration
REQ-025 Macro DPS_DEV_ARBITER_TIMEOUT_EN defined: WAIT counter increments per cycle; on reaching TIMEOUT with no response, SHALL go to RESP with oRSP_ERROR=1, oRSP_DATA=32'h0; counter clears on leaving WAIT.
REQ-026 Macro undefined: no counter logic; WAIT lasts until a response; oRSP_ERROR SHALL be constant 0.

Structure
REQ-027 Package dps_dev_arb_pkg SHALL hold the state encoding type, the 32-bit data-width constant, and the default N_REQ/TIMEOUT constants.
REQ-028 Round-robin selection SHALL be a combinational sub-module dps_rr_picker (inputs request vector, last grant; outputs one-hot grant and index).

Verification
REQ-029 After reset, iREQ_VALID=4'b0001, device returns 32'h04000000 one cycle after request -> oREQ_ACCEPT=0001 at cycle 1, oRSP_VALID=0001 with data 32'h04000000 at cycle 3.
REQ-030 iREQ_VALID=4'b1111 held continuously, each requester dropping after its accept -> grants in order 0,1,2,3, one every 4 cycles.
REQ-031 Requester 2 served, then iREQ_VALID=4'b0101 -> requester 0 granted next (wraps past 3); then requester 2.
REQ-032 TIMEOUT_EN, TIMEOUT=16, device silent -> oRSP_VALID[g]=1, oRSP_ERROR=1, data 32'h0 after 16 WAIT cycles; a late response 5 cycles later is ignored.
REQ-033 iRESET pulsed in WAIT, device responds after release -> no oRSP_VALID; next request served normally starting from requester 0.
REQ-034 Spurious iDEV_RSP_VALID in IDLE with data 32'hDEADBEEF -> no output change; next transaction returns the correct device data.
